// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath: op decode, stage-count helper and the pipeline stage record.
package alu_pkg;

   localparam int ALU_MAX_W = 64;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Operand/sum fields are sized for the widest datapath; narrower builds zero-extend.
   typedef struct packed {
      logic                 valid;
      logic                 sat;
      logic                 carry;
      logic [ALU_MAX_W-1:0] a;
      logic [ALU_MAX_W-1:0] b;
      logic [ALU_MAX_W-1:0] sum;
   } stage_t;

   function automatic int stages_f(input int width, input int chunk);
      return (chunk > 0) ? width / chunk : 0;
   endfunction

endpackage

// File: rtl/rca_chunk.sv
// CHUNK-bit combinational ripple-carry segment; also exports the carry into its MSB.
module rca_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);
   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int k = 0; k < CHUNK; k++) begin
         s[k]   = a[k] ^ b[k] ^ c[k];
         c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
      end
   end

   assign cout  = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit ripple segment per register stage.
// Define PIPE_ADDSUB_SAT_EN to add port sat, which clamps signed overflow to max/min.
module pipe_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             carry_in,
   input  logic             sub,
`ifdef PIPE_ADDSUB_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   localparam int STAGES = stages_f(WIDTH, CHUNK);
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SMAX = ~SMIN;

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (WIDTH > ALU_MAX_W)) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be a non-zero multiple of CHUNK and at most ALU_MAX_W");
   end

   op_e                          op;
   logic                         sat_in;
   stage_t                       src   [STAGES];
   stage_t                       nxt   [STAGES];
   stage_t                       stg_q [STAGES];
   logic [STAGES-1:0]            v;
   logic [STAGES-1:0]            rdy;
   logic [STAGES-1:0][CHUNK-1:0] s_w;
   logic [STAGES-1:0]            cout_w;
   logic [STAGES-1:0]            cmsb_w;
   logic [WIDTH-1:0]             raw_sum;
   logic [WIDTH-1:0]             fin_sum;
   logic                         fin_ovf;
   logic                         ovf_q;
   logic                         zero_q;
   logic                         neg_q;
   logic                         unused_bits;

   assign op = sub ? OP_SUB : OP_ADD;

`ifdef PIPE_ADDSUB_SAT_EN
   assign sat_in = sat;
`else
   assign sat_in = 1'b0;
`endif

   // Subtraction is folded in at entry: invert B and the borrow, then every stage just adds.
   always_comb begin
      src[0]       = '0;
      src[0].valid = in_valid;
      src[0].sat   = sat_in;
      src[0].a     = ALU_MAX_W'(op1);
      src[0].b     = ALU_MAX_W'((op == OP_SUB) ? ~op2 : op2);
      src[0].carry = (op == OP_SUB) ? ~carry_in : carry_in;
      for (int i = 1; i < STAGES; i++) begin
         src[i] = stg_q[i-1];
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      rca_chunk #(.CHUNK(CHUNK)) u_rca (
         .a     (src[i].a[i*CHUNK +: CHUNK]),
         .b     (src[i].b[i*CHUNK +: CHUNK]),
         .cin   (src[i].carry),
         .s     (s_w[i]),
         .cout  (cout_w[i]),
         .c_msb (cmsb_w[i])
      );
      assign v[i]   = stg_q[i].valid;
      assign rdy[i] = out_ready || !(&v[STAGES-1:i]);
   end

   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         nxt[i]                         = src[i];
         nxt[i].sum[i*CHUNK +: CHUNK]   = s_w[i];
         nxt[i].carry                   = cout_w[i];
      end
      raw_sum = nxt[STAGES-1].sum[WIDTH-1:0];
      fin_ovf = cmsb_w[STAGES-1] ^ cout_w[STAGES-1];
      fin_sum = raw_sum;
      // A wrapped-negative result means the true value overflowed upward.
      if (src[STAGES-1].sat && fin_ovf) begin
         fin_sum = raw_sum[WIDTH-1] ? SMAX : SMIN;
      end
      nxt[STAGES-1].sum[WIDTH-1:0] = fin_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stg_q[i] <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (rdy[i]) begin
               if (src[i].valid) begin
                  stg_q[i] <= nxt[i];
               end else begin
                  stg_q[i].valid <= 1'b0;
               end
            end
         end
         if (rdy[STAGES-1] && src[STAGES-1].valid) begin
            ovf_q  <= fin_ovf;
            zero_q <= (fin_sum == '0);
            neg_q  <= fin_sum[WIDTH-1];
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = stg_q[STAGES-1].valid;
   assign sum       = stg_q[STAGES-1].sum[WIDTH-1:0];
   assign carry_out = stg_q[STAGES-1].carry;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

   // Operand copies and early-stage MSB carries are dead once the last stage is loaded.
   assign unused_bits = ^{stg_q[STAGES-1], cmsb_w};

endmodule
